count_op_scheduler: RTL and testbench

COUNT_OP_SCHEDULER -- requirements
Module: count_op_scheduler

---
 rtl/count_op_scheduler_if.sv | 10 +
 rtl/count_op_scheduler.sv | 104 ++++++++++
 tb/tb_count_op_scheduler.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/count_op_scheduler_if.sv
// count_op_scheduler_if: op handshake bus between the scheduler and the counter datapath
interface count_op_scheduler_if;
    logic       op_valid;
    logic [1:0] op;
    logic [2:0] grant;
    logic       op_ready;

    modport master(output op_valid, op, grant, input op_ready);
    modport slave(input op_valid, op, grant, output op_ready);
endinterface

// File: rtl/count_op_scheduler.sv
// count_op_scheduler: debounces two buttons, adds a periodic tick, and arbitrates them into counter ops
module count_op_scheduler #(
    parameter int DB_CNT   = 4,
    parameter int TICK_DIV = 50000000
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic [1:0]            i_Push,
    count_op_scheduler_if.master  bus,
    output logic                  o_Overrun
);
    localparam int CW = $clog2(DB_CNT + 1);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] DB_LAST   = CW'(DB_CNT - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t        state;
    logic [1:0]    sync1, sync2, level, level_d;
    logic [CW-1:0] db_cnt [2];
    logic [TW-1:0] tick_cnt;
    logic [2:0]    pend, ev, clr, pick;
    logic [1:0]    press, pick_op;
    logic          tick, hs, last1;

    assign press   = level_d & ~level;
    assign tick    = tick_cnt == TICK_LAST;
    assign ev      = {press[1], press[0], tick};
    assign hs      = state == ISSUE && bus.op_ready;
    assign clr     = hs ? bus.grant : 3'b000;
    // push1 wins a tie unless it was the last button served
    assign pick    = (pend[2] && !(pend[1] && last1)) ? 3'b100 :
                     pend[1] ? 3'b010 :
                     pend[0] ? 3'b001 : 3'b000;
    assign pick_op = pick[2] ? 2'b10 : pick[1] ? 2'b11 : {1'b0, pick[0]};

    // synchronize the raw buttons and accept a level only after DB_CNT stable cycles
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sync1     <= '1;
            sync2     <= '1;
            level     <= '1;
            level_d   <= '1;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            sync1   <= i_Push;
            sync2   <= sync1;
            level_d <= level;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i] <= '0;
                    level[i]  <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + CW'(1);
                end
            end
        end
    end

    // free-running tick divider
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) tick_cnt <= '0;
        else       tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
    end

    // pending flags; a fresh event on the source being retired re-arms it without overrun
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            pend      <= '0;
            o_Overrun <= 1'b0;
        end else begin
            pend <= (pend & ~clr) | ev;
            if (|(ev & pend & ~clr)) o_Overrun <= 1'b1;
        end
    end

    // grant one pending source and hold the op until the datapath accepts it
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state        <= IDLE;
            bus.op_valid <= 1'b0;
            bus.op       <= 2'b00;
            bus.grant    <= 3'b000;
            last1        <= 1'b0;
        end else if (state == IDLE) begin
            if (|pend) begin
                state        <= ISSUE;
                bus.op_valid <= 1'b1;
                bus.op       <= pick_op;
                bus.grant    <= pick;
                if (|pick[2:1]) last1 <= pick[2];
            end
        end else if (bus.op_ready) begin
            state        <= IDLE;
            bus.op_valid <= 1'b0;
            bus.op       <= 2'b00;
            bus.grant    <= 3'b000;
        end
    end
endmodule

// File: tb/tb_count_op_scheduler.sv
// tb_count_op_scheduler: directed checks of debounce, arbitration, handshake and reset
module tb_count_op_scheduler;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] push = 2'b11;
    logic       overrun;

    count_op_scheduler_if bus();

    count_op_scheduler #(.DB_CNT(4), .TICK_DIV(16)) dut (
        .i_Clk(clk),
        .i_Rst(rst),
        .i_Push(push),
        .bus(bus),
        .o_Overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0, edge_no = 0;
    int vcnt = 0, n_p1 = 0, n_p0 = 0, n_tk = 0;
    int err_stab = 0, err_gap = 0, err_map = 0;
    logic       pv = 1'b0, pr = 1'b0;
    logic [1:0] pop = 2'b00;
    logic [2:0] pg = 3'b000;

    // watch every cycle: count handshakes per source, flag unstable ops, back-to-back valids and bad op codes
    always @(negedge clk) begin
        if (rst) begin
            pv <= 1'b0;
        end else begin
            pv  <= bus.op_valid;
            pr  <= bus.op_ready;
            pop <= bus.op;
            pg  <= bus.grant;
            if (bus.op_valid) begin
                vcnt <= vcnt + 1;
                if (!((bus.grant == 3'b100 && bus.op == 2'b10) ||
                      (bus.grant == 3'b010 && bus.op == 2'b11) ||
                      (bus.grant == 3'b001 && bus.op == 2'b01)))
                    err_map <= err_map + 1;
            end
            if (bus.op_valid && bus.op_ready) begin
                if (bus.grant == 3'b100) n_p1 <= n_p1 + 1;
                if (bus.grant == 3'b010) n_p0 <= n_p0 + 1;
                if (bus.grant == 3'b001) n_tk <= n_tk + 1;
            end
            if (pv && !pr && bus.op_valid && {bus.op, bus.grant} != {pop, pg})
                err_stab <= err_stab + 1;
            if (pv && pr && bus.op_valid)
                err_gap <= err_gap + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic to_edge(input int e);
        repeat (e - edge_no) @(posedge clk);
        edge_no = e;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_valid", 32'(bus.op_valid), 0);
        chk("rst_op", 32'(bus.op), 0);
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_overrun", 32'(overrun), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        edge_no = 0;
    endtask

    int b_v, b_1, b_0, b_t;

    initial begin
        // short glitch on push1 never becomes a press
        bus.op_ready = 1'b1;
        push = 2'b11;
        do_reset();
        b_v = vcnt; b_1 = n_p1; b_t = n_tk;
        push = 2'b01;
        to_edge(3);
        push = 2'b11;
        to_edge(14);
        chk("glitch_quiet", vcnt - b_v, 0);
        to_edge(40);
        chk("glitch_no_p1", n_p1 - b_1, 0);
        chk("tick_period", n_tk - b_t, 2);

        // held push1 gives exactly one DOUBLE with minimum latency
        bus.op_ready = 1'b1;
        do_reset();
        b_1 = n_p1;
        push = 2'b01;
        to_edge(7);
        chk("p1_not_yet", 32'(bus.op_valid), 0);
        to_edge(8);
        chk("p1_valid", 32'(bus.op_valid), 1);
        chk("p1_op", 32'(bus.op), 2);
        chk("p1_grant", 32'(bus.grant), 4);
        to_edge(9);
        chk("p1_one_cycle", 32'(bus.op_valid), 0);
        push = 2'b11;
        to_edge(40);
        chk("p1_single", n_p1 - b_1, 1);
        chk("p1_no_overrun", 32'(overrun), 0);

        // stalled tick op holds, a second tick overruns
        bus.op_ready = 1'b0;
        do_reset();
        to_edge(16);
        chk("tk_pending_idle", 32'(bus.op_valid), 0);
        to_edge(17);
        chk("tk_valid", 32'(bus.op_valid), 1);
        chk("tk_op", 32'(bus.op), 1);
        chk("tk_grant", 32'(bus.grant), 1);
        to_edge(25);
        chk("tk_hold_valid", 32'(bus.op_valid), 1);
        chk("tk_hold_op", 32'(bus.op), 1);
        to_edge(31);
        chk("tk_no_ovr_yet", 32'(overrun), 0);
        to_edge(32);
        chk("tk_overrun", 32'(overrun), 1);
        bus.op_ready = 1'b1;
        to_edge(33);
        chk("tk_done", 32'(bus.op_valid), 0);
        to_edge(34);
        chk("tk_no_repeat", 32'(bus.op_valid), 0);
        chk("tk_ovr_sticky", 32'(overrun), 1);

        // both buttons together: push1 then push0, split by an idle cycle
        bus.op_ready = 1'b1;
        do_reset();
        push = 2'b00;
        to_edge(8);
        chk("both_first_grant", 32'(bus.grant), 4);
        chk("both_first_op", 32'(bus.op), 2);
        to_edge(9);
        chk("both_gap", 32'(bus.op_valid), 0);
        to_edge(10);
        chk("both_second_valid", 32'(bus.op_valid), 1);
        chk("both_second_grant", 32'(bus.grant), 2);
        chk("both_second_op", 32'(bus.op), 3);
        to_edge(11);
        chk("both_end", 32'(bus.op_valid), 0);

        // after serving push1, a tie goes to push0
        bus.op_ready = 1'b1;
        do_reset();
        push = 2'b01;
        to_edge(8);
        chk("rr_seed", 32'(bus.grant), 4);
        to_edge(10);
        push = 2'b11;
        to_edge(20);
        push = 2'b00;
        to_edge(28);
        chk("rr_p0_first", 32'(bus.grant), 2);
        chk("rr_p0_op", 32'(bus.op), 3);
        to_edge(29);
        chk("rr_gap", 32'(bus.op_valid), 0);
        to_edge(30);
        chk("rr_p1_next", 32'(bus.grant), 4);
        push = 2'b11;

        // buttons and tick pending together: tick waits for both buttons
        bus.op_ready = 1'b1;
        do_reset();
        to_edge(9);
        push = 2'b00;
        to_edge(16);
        chk("mix_idle", 32'(bus.op_valid), 0);
        to_edge(17);
        chk("mix_g1", 32'(bus.grant), 4);
        to_edge(18);
        chk("mix_gap1", 32'(bus.op_valid), 0);
        to_edge(19);
        chk("mix_g2", 32'(bus.grant), 2);
        to_edge(20);
        chk("mix_gap2", 32'(bus.op_valid), 0);
        to_edge(21);
        chk("mix_g3", 32'(bus.grant), 1);
        chk("mix_op3", 32'(bus.op), 1);
        to_edge(22);
        chk("mix_end", 32'(bus.op_valid), 0);

        // reset during a presented HALVE discards it
        bus.op_ready = 1'b0;
        do_reset();
        push = 2'b10;
        to_edge(9);
        chk("mid_valid", 32'(bus.op_valid), 1);
        chk("mid_op", 32'(bus.op), 3);
        push = 2'b11;
        b_0 = n_p0;
        do_reset();
        bus.op_ready = 1'b1;
        b_v = vcnt;
        to_edge(14);
        chk("post_rst_quiet", vcnt - b_v, 0);
        chk("post_rst_no_p0", n_p0 - b_0, 0);

        chk("stable_hold", err_stab, 0);
        chk("idle_between", err_gap, 0);
        chk("op_grant_map", err_map, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
